// File: rtl/adci_pkg.sv
// rtl/adci_pkg.sv - shared constants, edge codes and state encodings for the ADC responder
package adci_pkg;

    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_FRAME_LEN   = 16;
    localparam int DEF_LEAD_ZEROS  = 5;
    localparam int DEF_SYNC_STAGES = 2;

    // Bit counters must reach FRAME_LEN, so five bits are enough
    localparam int CNT_W = 5;

    // Control bit that selects the channel for the following frame
    localparam int ADD0_BIT = 3;

    // Chip-select levels as seen on CSN
    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // Edge codes over a {previous, current} level history
    typedef enum logic [1:0] {
        NOEDGE  = 2'b00,
        RISING  = 2'b01,
        FALLING = 2'b10
    } edge_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/adci_sync_edge.sv
// rtl/adci_sync_edge.sv - multi-flop synchronizer with rising/falling edge pulses
module adci_sync_edge
    import adci_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [1:0]        hist;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign hist  = {prev_q, level};
    assign rise  = (hist == RISING);
    assign fall  = (hist == FALLING);

endmodule

// File: rtl/adci_responder.sv
// rtl/adci_responder.sv - ADC082S101-style SPI responder returning host-supplied samples
module adci_responder
    import adci_pkg::*;
#(
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              CSN,
    input  logic              SCK,
    input  logic              SDI,
    output logic              SDO,
    input  logic [BYTE_W-1:0] ch0_data,
    input  logic [BYTE_W-1:0] ch1_data,
    output logic              smp_strobe,
    output logic              smp_chan,
    output logic [BYTE_W-1:0] ctrl_word,
    output logic              ctrl_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int               TAIL_ZEROS = FRAME_LEN - LEAD_ZEROS - BYTE_W;
    localparam logic [CNT_W-1:0] LAST_RISE  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FALL_SAT   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CTRL_RISES = CNT_W'(BYTE_W);

    logic csn_level, csn_rise, csn_fall;
    logic sck_rise, sck_fall, unused_sck_level;
    logic sdi_level, unused_sdi_rise, unused_sdi_fall;

    state_e               state_q, state_d;
    logic                 abort;
    logic [CNT_W-1:0]     rise_cnt, fall_cnt;
    logic [FRAME_LEN-1:0] tx_sr;
    logic [BYTE_W-1:0]    ctrl_sr;
    logic                 sel_chan;

    // CSN idles deasserted and SCK idles high, so neither fakes an edge out of reset
    adci_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_DEASSERT)) u_sync_csn (
        .sys_clk(sys_clk), .rst_n(rst_n), .async_in(CSN),
        .level(csn_level), .rise(csn_rise), .fall(csn_fall)
    );

    adci_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
        .sys_clk(sys_clk), .rst_n(rst_n), .async_in(SCK),
        .level(unused_sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    adci_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .sys_clk(sys_clk), .rst_n(rst_n), .async_in(SDI),
        .level(sdi_level), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
    );

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; a CSN release together with the last rising edge still completes the frame
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csn_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (csn_rise) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sck_rise && rise_cnt == LAST_RISE) begin
                    state_d = ST_DONE;
                end else if (csn_rise) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = (csn_level == CS_ASSERT) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: sample latch, bit shifting, control capture and status pulses
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            SDO        <= 1'b0;
            smp_strobe <= 1'b0;
            smp_chan   <= 1'b0;
            ctrl_word  <= '0;
            ctrl_valid <= 1'b0;
            frame_err  <= 1'b0;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            tx_sr      <= '0;
            ctrl_sr    <= '0;
            sel_chan   <= 1'b0;
        end else begin
            smp_strobe <= 1'b0;
            ctrl_valid <= 1'b0;
            frame_err  <= abort;
            case (state_q)
                ST_LOAD: begin
                    tx_sr      <= {{LEAD_ZEROS{1'b0}}, (sel_chan ? ch1_data : ch0_data),
                                   {TAIL_ZEROS{1'b0}}};
                    smp_strobe <= 1'b1;
                    smp_chan   <= sel_chan;
                    rise_cnt   <= '0;
                    fall_cnt   <= '0;
                    SDO        <= 1'b0;
                end
                ST_ACTIVE: begin
                    if (sck_fall) begin
                        if (fall_cnt != FALL_SAT) begin
                            SDO      <= tx_sr[FRAME_LEN-1];
                            tx_sr    <= tx_sr << 1;
                            fall_cnt <= fall_cnt + 1'b1;
                        end else begin
                            SDO <= 1'b0;
                        end
                    end
                    if (sck_rise) begin
                        rise_cnt <= rise_cnt + 1'b1;
                        if (rise_cnt < CTRL_RISES) ctrl_sr <= {ctrl_sr[BYTE_W-2:0], sdi_level};
                    end
                    if (abort) SDO <= 1'b0;
                end
                ST_DONE: begin
                    ctrl_word  <= ctrl_sr;
                    ctrl_valid <= 1'b1;
                    sel_chan   <= ctrl_sr[ADD0_BIT];
                end
                default: SDO <= 1'b0;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adci_responder.sv
// tb/tb_adci_responder.sv - directed self-checking bench for adci_responder
`timescale 1ns/1ps
module tb_adci_responder;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       CSN     = 1'b1;
    logic       SCK     = 1'b1;
    logic       SDI     = 1'b0;
    logic [7:0] ch0_data = 8'h00;
    logic [7:0] ch1_data = 8'h00;
    logic       SDO, smp_strobe, smp_chan, ctrl_valid, frame_err, busy;
    logic [7:0] ctrl_word;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int valid_cnt  = 0;
    int err_cnt    = 0;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] ch0;
        logic [7:0] ch1;
        logic [7:0] exp_sample;
        logic [7:0] exp_cw;
        logic       exp_chan;
    } vec_t;

    vec_t vecs [5];

    adci_responder dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .CSN(CSN), .SCK(SCK), .SDI(SDI), .SDO(SDO),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .smp_strobe(smp_strobe),
        .smp_chan(smp_chan), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
        .frame_err(frame_err), .busy(busy)
    );

    // 10 ns sys_clk; SCK half period is 4 sys_clk (8x oversampling)
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (smp_strobe) strobe_cnt++;
        if (ctrl_valid) valid_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One master transaction: optional CSN drop, n_rises SCK cycles (fall then rise), optional CSN release
    task automatic run_frame(input logic [7:0] ctrl, input bit drop_csn, input bit raise_csn,
                             input int n_rises, input bit do_swap, input logic [7:0] swap_val,
                             output logic [15:0] word);
        int lat;
        word = '0;
        if (drop_csn) begin
            @(negedge sys_clk);
            CSN = 1'b0;
            lat = 0;
            while (!smp_strobe && lat < 12) begin
                @(negedge sys_clk);
                lat++;
            end
            check("csn_to_strobe", lat, 4);
            if (do_swap) begin
                repeat (2) @(negedge sys_clk);
                ch0_data = swap_val;
            end
        end
        for (int k = 1; k <= n_rises; k++) begin
            @(negedge sys_clk);
            SCK = 1'b0;
            SDI = (k <= 8) ? ctrl[8-k] : 1'b0;
            repeat (3) @(negedge sys_clk);
            @(negedge sys_clk);
            word = {word[14:0], SDO};
            SCK  = 1'b1;
            if (raise_csn && k == n_rises) CSN = 1'b1;
            repeat (3) @(negedge sys_clk);
        end
    endtask

    task automatic do_single(input string tag, input logic [7:0] ctrl, input logic [7:0] exp_sample,
                             input logic [7:0] exp_cw, input logic exp_chan);
        int s0, v0, e0;
        logic [15:0] w;
        s0 = strobe_cnt; v0 = valid_cnt; e0 = err_cnt;
        run_frame(ctrl, 1'b1, 1'b1, 16, 1'b0, 8'h00, w);
        check($sformatf("%s_valid_early", tag), ctrl_valid, 1'b0);
        @(negedge sys_clk);
        check($sformatf("%s_valid_at_4", tag), ctrl_valid, 1'b1);
        repeat (3) @(negedge sys_clk);
        check($sformatf("%s_sample", tag), w[10:3], exp_sample);
        check($sformatf("%s_pad", tag), {w[15:11], w[2:0]}, 8'h00);
        check($sformatf("%s_ctrl_word", tag), ctrl_word, exp_cw);
        check($sformatf("%s_smp_chan", tag), smp_chan, exp_chan);
        check($sformatf("%s_strobes", tag), strobe_cnt - s0, 1);
        check($sformatf("%s_valids", tag), valid_cnt - v0, 1);
        check($sformatf("%s_errs", tag), err_cnt - e0, 0);
        check($sformatf("%s_idle", tag), {busy, SDO}, 2'b00);
    endtask

    logic [15:0] w;
    int s0, v0, e0;
    logic [7:0] cont_ctrl [4];
    logic [7:0] cont_exp  [4];

    initial begin
        //              ctrl   ch0    ch1    sample cw     chan
        vecs[0] = '{8'h08, 8'hA5, 8'h5A, 8'hA5, 8'h08, 1'b0};
        vecs[1] = '{8'h00, 8'hA5, 8'h5A, 8'h5A, 8'h00, 1'b1};
        vecs[2] = '{8'hF7, 8'h81, 8'h7E, 8'h81, 8'hF7, 1'b0};
        vecs[3] = '{8'h08, 8'hFF, 8'h00, 8'hFF, 8'h08, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'h01, 8'h01, 8'hFF, 1'b1};
        cont_ctrl[0] = 8'h08; cont_ctrl[1] = 8'h08; cont_ctrl[2] = 8'h00; cont_ctrl[3] = 8'h00;
        cont_exp[0]  = 8'h3C; cont_exp[1]  = 8'hC3; cont_exp[2]  = 8'hC3; cont_exp[3]  = 8'h3C;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_outputs", {SDO, smp_strobe, smp_chan, ctrl_valid, frame_err, busy}, 6'b0);
        check("rst_ctrl_word", ctrl_word, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("rst_no_pulses", strobe_cnt + valid_cnt + err_cnt, 0);

        // Table of independent single frames
        for (int i = 0; i < 5; i++) begin
            ch0_data = vecs[i].ch0;
            ch1_data = vecs[i].ch1;
            do_single($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].exp_sample,
                      vecs[i].exp_cw, vecs[i].exp_chan);
        end

        // Abort after 7 rising edges with a control byte that would clear ADD0
        s0 = strobe_cnt; v0 = valid_cnt; e0 = err_cnt;
        run_frame(8'h00, 1'b1, 1'b0, 7, 1'b0, 8'h00, w);
        check("abort_busy", busy, 1'b1);
        CSN = 1'b1;
        repeat (8) @(negedge sys_clk);
        check("abort_errs", err_cnt - e0, 1);
        check("abort_valids", valid_cnt - v0, 0);
        check("abort_strobes", strobe_cnt - s0, 1);
        check("abort_ctrl_word", ctrl_word, 8'hFF);
        check("abort_sdo_busy", {SDO, busy}, 2'b00);
        ch0_data = 8'h96; ch1_data = 8'h5A;
        do_single("post_abort", 8'h08, 8'h5A, 8'h08, 1'b1);

        // Reset after rising edge 9; channel 1 data bit 4 is on SDO at that point
        run_frame(8'h00, 1'b1, 1'b0, 9, 1'b0, 8'h00, w);
        check("pre_reset_sdo", SDO, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_sdo", SDO, 1'b0);
        CSN = 1'b1; SCK = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("mid_reset_state", {busy, smp_chan, ctrl_word}, 10'h000);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        ch0_data = 8'h42;
        do_single("post_reset", 8'h00, 8'h42, 8'h00, 1'b0);

        // Continuous frames with CSN held low; ADD0 takes effect one frame later
        ch0_data = 8'h3C; ch1_data = 8'hC3;
        s0 = strobe_cnt; v0 = valid_cnt; e0 = err_cnt;
        for (int f = 0; f < 4; f++) begin
            run_frame(cont_ctrl[f], f == 0, f == 3, 16, 1'b0, 8'h00, w);
            check($sformatf("cont%0d_sample", f), w[10:3], cont_exp[f]);
        end
        repeat (6) @(negedge sys_clk);
        check("cont_strobes", strobe_cnt - s0, 4);
        check("cont_valids", valid_cnt - v0, 4);
        check("cont_errs", err_cnt - e0, 0);
        check("cont_ctrl_word", ctrl_word, 8'h00);

        // Sample is frozen at LOAD: change ch0 two cycles after smp_strobe
        ch0_data = 8'h11;
        run_frame(8'h00, 1'b1, 1'b1, 16, 1'b1, 8'hEE, w);
        repeat (6) @(negedge sys_clk);
        check("stable_cur_sample", w[10:3], 8'h11);
        do_single("stable_next", 8'h00, 8'hEE, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
